sdram_slot_arb: RTL and testbench

Slot scheduler and three-port arbiter in front of the 64 MHz SDRAM controller. It generates the controller's `sync` strobe every 8 clocks, so each 8-cycle slot is one 8 MHz DRAM access. It picks one requester per slot (video, CPU, DMA) and drives the controller's single oe/we/addr/din/ds port. When no request is pending, or when refresh is due, it leaves the slot idle so the controller issues auto-refresh.

---
 rtl/sdram_arb_pkg.sv | 17 +
 rtl/sdram_slot_arb_if.sv | 30 +++
 rtl/sdram_arb_pick.sv | 23 ++
 rtl/sdram_slot_arb.sv | 125 ++++++++++++
 tb/tb_sdram_slot_arb.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared constants and request record for the SDRAM slot arbiter.
package sdram_arb_pkg;

  localparam int NPORT    = 3;
  localparam int P_VIDEO  = 0;
  localparam int P_CPU    = 1;
  localparam int P_DMA    = 2;
  localparam int SLOT_LEN = 8;

  typedef struct packed {
    logic        wr;
    logic [23:0] addr;
    logic [15:0] wdata;
    logic [1:0]  ds;
  } ram_req_t;

endpackage

// File: rtl/sdram_slot_arb_if.sv
// Requester ports and SDRAM controller port bundled for the slot arbiter.
interface sdram_slot_arb_if;
  import sdram_arb_pkg::*;

  logic [NPORT-1:0]       req;
  logic [NPORT-1:0]       wr;
  logic [NPORT-1:0][23:0] addr;
  logic [NPORT-1:0][15:0] wdata;
  logic [NPORT-1:0][1:0]  ds;
  logic [NPORT-1:0]       done;
  logic [NPORT-1:0][15:0] rdata;
  logic                   ram_sync;
  logic                   ram_oe;
  logic                   ram_we;
  logic [23:0]            ram_addr;
  logic [15:0]            ram_din;
  logic [1:0]             ram_ds;
  logic [15:0]            ram_dout;

  modport slave (
    input  req, wr, addr, wdata, ds, ram_dout,
    output done, rdata, ram_sync, ram_oe, ram_we, ram_addr, ram_din, ram_ds
  );

  modport master (
    output req, wr, addr, wdata, ds, ram_dout,
    input  done, rdata, ram_sync, ram_oe, ram_we, ram_addr, ram_din, ram_ds
  );

endinterface

// File: rtl/sdram_arb_pick.sv
// Combinational slot winner: video first, then CPU, unless a starved DMA jumps the CPU.
module sdram_arb_pick
  import sdram_arb_pkg::*;
(
  input  logic [NPORT-1:0] i_elig,
  input  logic             i_starve_hit,
  input  logic             i_force_idle,
  output logic [NPORT-1:0] o_gnt,
  output logic             o_valid
);

  always_comb begin
    o_gnt = '0;
    if (!i_force_idle) begin
      if (i_elig[P_VIDEO])                      o_gnt[P_VIDEO] = 1'b1;
      else if (i_elig[P_DMA] && i_starve_hit)   o_gnt[P_DMA]   = 1'b1;
      else if (i_elig[P_CPU])                   o_gnt[P_CPU]   = 1'b1;
      else if (i_elig[P_DMA])                   o_gnt[P_DMA]   = 1'b1;
    end
    o_valid = |o_gnt;
  end

endmodule

// File: rtl/sdram_slot_arb.sv
// Slot scheduler: one DRAM access per 8-clock slot, refresh via idle slots.
module sdram_slot_arb
  import sdram_arb_pkg::*;
#(
  parameter int SLOT_LEN   = 8,
  parameter int INIT_SLOTS = 32,
  parameter int REF_MAX    = 32,
  parameter int STARVE_MAX = 4
) (
  input logic            clk,
  input logic            reset,
  sdram_slot_arb_if.slave bus
);

  localparam int PH_W     = $clog2(SLOT_LEN);
  localparam int BUSY_W   = $clog2(REF_MAX + 1);
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam int INIT_W   = $clog2(INIT_SLOTS + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SLOT_LEN - 1);

  logic [PH_W-1:0]        r_ph;
  logic                   r_sync;
  logic                   r_oe;
  logic                   r_we;
  logic [23:0]            r_addr;
  logic [15:0]            r_din;
  logic [1:0]             r_ds;
  logic [NPORT-1:0]       r_gnt;
  logic [NPORT-1:0]       r_done;
  logic [NPORT-1:0][15:0] r_rdata;
  logic [BUSY_W-1:0]      r_busy;
  logic [STARVE_W-1:0]    r_starve;
  logic [INIT_W-1:0]      r_init;

  logic                   w_slot_end;
  logic                   w_starve_hit;
  logic                   w_force_idle;
  logic                   w_valid;
  logic [NPORT-1:0]       w_elig;
  logic [NPORT-1:0]       w_gnt;
  ram_req_t               w_win;

  // The port whose slot is ending cannot win the very next slot.
  assign w_slot_end   = (r_ph == PH_LAST);
  assign w_elig       = bus.req & ~r_gnt;
  assign w_starve_hit = (r_starve >= STARVE_W'(STARVE_MAX));
  assign w_force_idle = (r_init != '0) || (r_busy >= BUSY_W'(REF_MAX));

  sdram_arb_pick u_pick (
    .i_elig       (w_elig),
    .i_starve_hit (w_starve_hit),
    .i_force_idle (w_force_idle),
    .o_gnt        (w_gnt),
    .o_valid      (w_valid)
  );

  always_comb begin
    w_win = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (w_gnt[i]) begin
        w_win.wr    = bus.wr[i];
        w_win.addr  = bus.addr[i];
        w_win.wdata = bus.wdata[i];
        w_win.ds    = bus.ds[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ph     <= PH_LAST;
      r_sync   <= 1'b0;
      r_oe     <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_din    <= '0;
      r_ds     <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_rdata  <= '0;
      r_busy   <= '0;
      r_starve <= '0;
      r_init   <= INIT_W'(INIT_SLOTS);
    end else begin
      r_ph   <= w_slot_end ? '0 : r_ph + PH_W'(1);
      r_sync <= w_slot_end;
      r_done <= '0;
      if (w_slot_end) begin
        // r_oe still describes the finishing slot, so it marks a read completion.
        for (int i = 0; i < NPORT; i++) begin
          if (r_gnt[i]) begin
            r_done[i] <= 1'b1;
            if (r_oe) r_rdata[i] <= bus.ram_dout;
          end
        end
        r_gnt <= w_gnt;
        if (w_valid) begin
          r_oe   <= ~w_win.wr;
          r_we   <= w_win.wr;
          r_addr <= w_win.addr;
          r_din  <= w_win.wdata;
          r_ds   <= w_win.ds;
          r_busy <= r_busy + BUSY_W'(1);
        end else begin
          r_oe   <= 1'b0;
          r_we   <= 1'b0;
          r_busy <= '0;
        end
        if (r_init != '0) r_init <= r_init - INIT_W'(1);
        if (w_gnt[P_DMA] || !bus.req[P_DMA]) r_starve <= '0;
        else if (w_elig[P_DMA] && !w_starve_hit) r_starve <= r_starve + STARVE_W'(1);
      end
    end
  end

  assign bus.done     = r_done;
  assign bus.rdata    = r_rdata;
  assign bus.ram_sync = r_sync;
  assign bus.ram_oe   = r_oe;
  assign bus.ram_we   = r_we;
  assign bus.ram_addr = r_addr;
  assign bus.ram_din  = r_din;
  assign bus.ram_ds   = r_ds;

endmodule

// File: tb/tb_sdram_slot_arb.sv
// Randomized bench for sdram_slot_arb against a slot-level reference model.
module tb_sdram_slot_arb;
  import sdram_arb_pkg::*;

  localparam int INIT_SLOTS = 32;
  localparam int REF_MAX    = 32;
  localparam int STARVE_MAX = 4;
  localparam int MODE_HOLD  = 0;
  localparam int MODE_ALL   = 1;
  localparam int MODE_RAND  = 2;

  logic clk = 1'b0;
  logic reset;
  logic [15:0] ramDout;

  sdram_slot_arb_if bus();
  assign bus.ram_dout = ramDout;

  sdram_slot_arb #(
    .SLOT_LEN   (8),
    .INIT_SLOTS (INIT_SLOTS),
    .REF_MAX    (REF_MAX),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int nChecks, nErrors;
  int cyc, slotIdx, firstGrant, mode;
  bit doutFixed;

  // Reference model state, one decision per slot.
  int          mInit, mBusy, mStarve, mCur;
  bit          mCurWr, mOe, mWe;
  logic [23:0] mAddr;
  logic [15:0] mDin;
  logic [1:0]  mDs;
  logic [2:0]  mDone;
  logic [15:0] mRdata [3];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mInit = INIT_SLOTS; mBusy = 0; mStarve = 0; mCur = -1;
    mCurWr = 0; mOe = 0; mWe = 0; mAddr = '0; mDin = '0; mDs = '0; mDone = '0;
    for (int i = 0; i < 3; i++) mRdata[i] = '0;
    cyc = 0; slotIdx = 0; firstGrant = 0;
  endtask

  task automatic modelSlot();
    int win;
    logic [2:0] elig;
    mDone = 3'b000;
    if (mCur >= 0) begin
      mDone[mCur] = 1'b1;
      if (!mCurWr) mRdata[mCur] = ramDout;
    end
    elig = bus.req;
    if (mCur >= 0) elig[mCur] = 1'b0;
    win = -1;
    if (mInit == 0 && mBusy < REF_MAX && elig != 3'b000) begin
      if (elig[P_VIDEO])                            win = P_VIDEO;
      else if (elig[P_DMA] && mStarve >= STARVE_MAX) win = P_DMA;
      else if (elig[P_CPU])                         win = P_CPU;
      else                                          win = P_DMA;
    end
    if (win == P_DMA || !bus.req[P_DMA]) mStarve = 0;
    else if (elig[P_DMA]) mStarve = (mStarve + 1 > STARVE_MAX) ? STARVE_MAX : mStarve + 1;
    if (mInit > 0) mInit--;
    mCur = win;
    slotIdx++;
    if (win >= 0) begin
      mBusy++;
      mCurWr = bus.wr[win];
      mOe = !mCurWr; mWe = mCurWr;
      mAddr = bus.addr[win]; mDin = bus.wdata[win]; mDs = bus.ds[win];
    end else begin
      mBusy = 0; mOe = 0; mWe = 0;
    end
  endtask

  task automatic newFields(input int i);
    bus.wr[i]    = 1'($urandom);
    bus.addr[i]  = 24'($urandom);
    bus.wdata[i] = 16'($urandom);
    bus.ds[i]    = 2'($urandom);
  endtask

  task automatic applyStimulus();
    int ph;
    ph = (cyc - 1) % 8;
    if (ph == 0) ramDout = doutFixed ? 16'hBEEF : 16'($urandom);
    if (mode == MODE_ALL) begin
      bus.req = 3'b111;
      if (ph == 0) for (int i = 0; i < 3; i++) if (mDone[i]) newFields(i);
    end else if (mode == MODE_RAND) begin
      for (int i = 0; i < 3; i++) begin
        if (ph == 0 && mDone[i]) begin
          if ($urandom_range(3) == 0) bus.req[i] = 1'b0;
          else begin bus.req[i] = 1'b1; newFields(i); end
        end else if (!bus.req[i]) begin
          if ($urandom_range(15) == 0) begin bus.req[i] = 1'b1; newFields(i); end
        end else if ($urandom_range(63) == 0) begin
          bus.req[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic checkAll();
    int ph;
    ph = (cyc - 1) % 8;
    checkOutput("sync", bus.ram_sync, ph == 0);
    checkOutput("oe", bus.ram_oe, mOe);
    checkOutput("we", bus.ram_we, mWe);
    checkOutput("addr", bus.ram_addr, mAddr);
    checkOutput("din", bus.ram_din, mDin);
    checkOutput("ds", bus.ram_ds, mDs);
    checkOutput("done", bus.done, (ph == 0) ? mDone : 3'b000);
    for (int i = 0; i < 3; i++) checkOutput($sformatf("rdata%0d", i), bus.rdata[i], mRdata[i]);
    if (firstGrant == 0 && (bus.ram_oe || bus.ram_we)) firstGrant = slotIdx;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    cyc++;
    if ((cyc - 1) % 8 == 0) modelSlot();
    @(negedge clk);
    checkAll();
    applyStimulus();
  endtask

  task automatic runToPhase(input int p);
    for (int k = 0; k < 8; k++) begin
      if ((cyc - 1) % 8 == p) break;
      stepCycle();
    end
  endtask

  task automatic checkResetValues(input string pfx);
    checkOutput($sformatf("%s_sync", pfx), bus.ram_sync, 1'b0);
    checkOutput($sformatf("%s_oe", pfx), bus.ram_oe, 1'b0);
    checkOutput($sformatf("%s_we", pfx), bus.ram_we, 1'b0);
    checkOutput($sformatf("%s_addr", pfx), bus.ram_addr, 24'h0);
    checkOutput($sformatf("%s_din", pfx), bus.ram_din, 16'h0);
    checkOutput($sformatf("%s_ds", pfx), bus.ram_ds, 2'b00);
    checkOutput($sformatf("%s_done", pfx), bus.done, 3'b000);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("%s_rdata%0d", pfx, i), bus.rdata[i], 16'h0);
  endtask

  initial begin
    int hits, doneSeen;
    bit found;
    logic [15:0] keepRdata;
    nChecks = 0; nErrors = 0;
    mode = MODE_HOLD; doutFixed = 1'b1; ramDout = 16'hBEEF;
    bus.req = '0; bus.wr = '0; bus.addr = '0; bus.wdata = '0; bus.ds = '0;
    reset = 1'b0;
    modelReset();
    #1 reset = 1'b1;
    @(negedge clk); @(negedge clk);
    checkResetValues("por");

    // Init window then a CPU read returning BEEF.
    bus.req = 3'b010; bus.wr[P_CPU] = 1'b0; bus.addr[P_CPU] = 24'h012345;
    reset = 1'b0;
    hits = 0;
    for (int c = 0; c < 265; c++) begin
      stepCycle();
      if (bus.ram_oe && bus.ram_addr == 24'h012345) hits++;
    end
    checkOutput("first_grant_slot", firstGrant, 33);
    checkOutput("cpu_slot_hits", hits, 8);
    checkOutput("cpu_done", bus.done[P_CPU], 1'b1);
    checkOutput("cpu_rdata", bus.rdata[P_CPU], 16'hBEEF);
    bus.req = '0;

    // All ports requesting continuously: priority, starvation, forced refresh.
    doutFixed = 1'b0;
    mode = MODE_ALL;
    for (int c = 0; c < 1200; c++) stepCycle();

    // DMA write with lower strobe only.
    mode = MODE_HOLD;
    bus.req = '0;
    for (int c = 0; c < 16; c++) stepCycle();
    runToPhase(0);
    keepRdata = mRdata[P_DMA];
    bus.req = 3'b100; bus.wr[P_DMA] = 1'b1; bus.wdata[P_DMA] = 16'hA55A;
    bus.ds[P_DMA] = 2'b01; bus.addr[P_DMA] = 24'($urandom);
    hits = 0; doneSeen = 0;
    for (int c = 0; c < 48; c++) begin
      stepCycle();
      if (bus.ram_we && bus.ram_din == 16'hA55A && bus.ram_ds == 2'b01) hits++;
      if (bus.done[P_DMA]) doneSeen++;
      if ((cyc - 1) % 8 == 0 && mDone[P_DMA]) bus.req[P_DMA] = 1'b0;
    end
    checkOutput("dma_wr_hits", hits, 8);
    checkOutput("dma_wr_done", doneSeen, 1);
    checkOutput("dma_wr_rdata_keep", bus.rdata[P_DMA], keepRdata);

    // Random traffic.
    mode = MODE_RAND;
    for (int c = 0; c < 2400; c++) stepCycle();

    // Reset in S4 of a granted CPU read.
    mode = MODE_HOLD;
    bus.req = '0;
    for (int c = 0; c < 16; c++) stepCycle();
    bus.req = 3'b010; bus.wr[P_CPU] = 1'b0; bus.addr[P_CPU] = 24'($urandom);
    found = 1'b0;
    for (int c = 0; c < 80; c++) begin
      stepCycle();
      if (mCur == P_CPU && (cyc - 1) % 8 == 4) begin found = 1'b1; break; end
    end
    if (!found) begin
      checkOutput("rst_find_slot", 1'b0, 1'b1);
    end else begin
      checkOutput("rst_pre_oe", bus.ram_oe, 1'b1);
      reset = 1'b1;
      #1;
      checkResetValues("midrst");
      modelReset();
      @(negedge clk); @(negedge clk);
      checkResetValues("midrst_hold");
      reset = 1'b0;
      for (int c = 0; c < 280; c++) stepCycle();
      checkOutput("reinit_first_grant", firstGrant, 33);
      mode = MODE_RAND;
      for (int c = 0; c < 480; c++) stepCycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
